pipe_ctrl_unit: RTL
===================

# pipe_ctrl_unit

Registered, stall-aware successor to the combinational control unit. It decodes a full RV32IM instruction word into the control bundle and holds the bundle in an ID/EX output register with stall and flush support. A multi-cycle sequencer for M-extension ops (parametrised latency) holds the pipeline until the multiplier/divider result is due. It sits between the IF/ID register and the execute stage.

## Interface
- `MUL_CYCLES`, default 2: total cycles a MUL* op occupies the output register; range 1..2^CNT_W.
- `DIV_CYCLES`, default 8: total cycles a DIV*/REM* op occupies the output register; range 1..2^CNT_W.
- `CNT_W`, default 4: width of the sequencer down-counter.
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RESET`  in  1  asynchronous, active-high reset.
- `INSTR`  in  32  instruction word (OP=[6:0], FUN3=[14:12], FUN7=[31:25]).
- `IN_VALID`  in  1  INSTR is a real instruction.
- `STALL_IN`  in  1  downstream hazard stall; hold the output register.
- `FLUSH`  in  1  squash the output register; overrides everything except RESET.
- `VALID_OUT`  out  1  bundle holds a live instruction.
- `ILLEGAL`  out  1  registered: the last loaded instruction was undecodable.
- `STALL_OUT`  out  1  sequencer busy; upstream must hold INSTR.
- `ALU_OP` 5, `MEM_READ` 3, `MEM_WRITE` 3, `IMMI_SEL` 3, `MEM_TO_REG` 2, `ALU_SOURCE` 2, `REG_WRITE` 1, `BRANCH` 1, `PC_SEL` 1: all out, registered control bundle.

## Operation
- Decode is combinational from INSTR with standard RV32 opcodes: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111.
- ALU_OP encodings:
  - Integer ops use {FUN7[5], 1'b0, FUN3}: add 00000, sll 00001, slt 00010, sltu 00011, xor 00100, srl 00101, or 00110, and 00111, sub 10000, sra 10101. I-ALU ops use FUN7[5] only for srai; addi is never sub.
  - Branches: 01000 + FUN3 (beq 01000, bne 01001, blt 01100, bge 01101, bltu 01110, bgeu 01111).
  - Forward-immediate (LUI): 01010.
  - M ops (FUN7=0000001): {2'b11, FUN3}.
  - Address calculations use add.
- IMMI_SEL: 000 none, 001 I, 010 S, 011 U, 100 B, 101 J.
- MEM_TO_REG: 00 ALU, 01 memory, 10 PC+4 (JAL/JALR).
- ALU_SOURCE: 00 rs1/rs2, 01 rs1/imm, 10 PC/imm (AUIPC, JAL).
- MEM_READ: lb 001, lh 010, lw 011, lbu 100, lhu 101. MEM_WRITE: sb 001, sh 010, sw 011. Otherwise 000.
- PC_SEL=1 only for JAL/JALR; BRANCH=1 only for branch opcodes.
- Illegal instruction (unknown opcode, FUN3 or FUN7 combination, including unlisted load/store FUN3) while IN_VALID=1: load an all-zero bundle with VALID_OUT=0 and ILLEGAL=1.
- Register update priority at each edge:
  1. FLUSH: zero bundle, VALID_OUT=0, ILLEGAL=0, sequencer to IDLE.
  2. STALL_OUT or STALL_IN: hold.
  3. Otherwise: load decode; VALID_OUT=IN_VALID & ~illegal. IN_VALID=0 loads a zero bundle.
- Sequencer states:
  - IDLE -> MD_RUN when a valid M op is loaded and its N (MUL_CYCLES for FUN3[2]=0, else DIV_CYCLES) is greater than 1. The counter loads N-1 on that edge.
  - MD_RUN: decrement each edge, independent of STALL_IN. Counter==1 at an edge -> IDLE.
  - FLUSH in any state -> IDLE with counter 0.
- STALL_OUT = (state==MD_RUN), decoded combinationally from the state register.

## Timing
- Reset: all bundle outputs 0, VALID_OUT=0, ILLEGAL=0, STALL_OUT=0, state IDLE, counter 0.
- Decode-to-output latency is one cycle.
- An M op is presented for exactly N cycles (STALL_OUT high for N-1 of them) before the next instruction can load, unless STALL_IN extends the hold.
- RESET or FLUSH mid-MD_RUN: STALL_OUT low by the next cycle; the aborted op is never re-presented.
- STALL_IN and FLUSH together: FLUSH wins.

## Test plan
- Reset released, INSTR=add x3,x1,x2 (0x002081B3), IN_VALID=1 -> next edge: ALU_OP=00000, REG_WRITE=1, VALID_OUT=1, STALL_OUT=0.
- Sweep of every load/store/branch FUN3 -> MEM_READ, MEM_WRITE, ALU_OP and IMMI_SEL match the encodings above. Load FUN3=011 (ld) -> ILLEGAL=1, VALID_OUT=0.
- div x5,x6,x7 (0x027342B3) with DIV_CYCLES=8 -> ALU_OP=11100, STALL_OUT high for exactly 7 cycles, next instruction loads on the 8th edge. With MUL_CYCLES=1, mul -> STALL_OUT never asserts.
- FLUSH asserted in the 3rd cycle of a DIV -> next edge: VALID_OUT=0, STALL_OUT=0, following instruction loads normally.
- STALL_IN held for 3 cycles over a lui x1,0x12345 (0x123450B7) -> bundle (ALU_OP=01010, IMMI_SEL=011, ALU_SOURCE=01) unchanged for 3 cycles. FLUSH and STALL_IN together -> bundle zeroed.
- RESET pulsed asynchronously mid-MD_RUN, between clock edges -> all outputs 0 immediately, without waiting for an edge.

Source files
------------

// File: rtl/pipe_ctrl_unit.sv
// RV32IM decode into a registered ID/EX control bundle, with stall/flush handling
// and a down-counting sequencer that holds the stage while an M-extension op completes.
module pipe_ctrl_unit #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 8,
  parameter int CNT_W      = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTR,
  input  logic        IN_VALID,
  input  logic        STALL_IN,
  input  logic        FLUSH,
  output logic        VALID_OUT,
  output logic        ILLEGAL,
  output logic        STALL_OUT,
  output logic [4:0]  ALU_OP,
  output logic [2:0]  MEM_READ,
  output logic [2:0]  MEM_WRITE,
  output logic [2:0]  IMMI_SEL,
  output logic [1:0]  MEM_TO_REG,
  output logic [1:0]  ALU_SOURCE,
  output logic        REG_WRITE,
  output logic        BRANCH,
  output logic        PC_SEL
);

  typedef struct packed {
    logic [4:0] alu_op;
    logic [2:0] mem_read;
    logic [2:0] mem_write;
    logic [2:0] immi_sel;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_source;
    logic       reg_write;
    logic       branch;
    logic       pc_sel;
  } ctrl_t;

  typedef enum logic {S_IDLE, S_MD_RUN} state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Counter preload is N-1: the load edge itself accounts for the first cycle.
  localparam logic [CNT_W-1:0] MUL_LD  = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [6:0] op;
  logic [2:0] fun3;
  logic [6:0] fun7;
  logic       unused_instr_bits;

  assign op                = INSTR[6:0];
  assign fun3              = INSTR[14:12];
  assign fun7              = INSTR[31:25];
  assign unused_instr_bits = ^{INSTR[24:15], INSTR[11:7]};

  ctrl_t dec;
  logic  dec_ill;
  logic  dec_mop;

  always_comb begin
    dec     = '0;
    dec_ill = 1'b0;
    dec_mop = 1'b0;
    case (op)
      OP_R: begin
        dec.reg_write = 1'b1;
        case (fun7)
          7'b0000000: dec.alu_op = {2'b00, fun3};
          7'b0100000: begin
            dec.alu_op = {2'b10, fun3};
            dec_ill    = (fun3 != 3'b000) && (fun3 != 3'b101);
          end
          7'b0000001: begin
            dec.alu_op = {2'b11, fun3};
            dec_mop    = 1'b1;
          end
          default: dec_ill = 1'b1;
        endcase
      end
      OP_IMM: begin
        dec.reg_write  = 1'b1;
        dec.immi_sel   = 3'b001;
        dec.alu_source = 2'b01;
        dec.alu_op     = {2'b00, fun3};
        // Only the shift-right encoding carries an arithmetic variant in FUN7.
        if (fun3 == 3'b001) begin
          dec_ill = (fun7 != 7'b0000000);
        end else if (fun3 == 3'b101) begin
          dec.alu_op = {fun7[5], 1'b0, fun3};
          dec_ill    = (fun7 != 7'b0000000) && (fun7 != 7'b0100000);
        end
      end
      OP_LOAD: begin
        dec.reg_write  = 1'b1;
        dec.immi_sel   = 3'b001;
        dec.alu_source = 2'b01;
        dec.mem_to_reg = 2'b01;
        case (fun3)
          3'b000:  dec.mem_read = 3'b001;
          3'b001:  dec.mem_read = 3'b010;
          3'b010:  dec.mem_read = 3'b011;
          3'b100:  dec.mem_read = 3'b100;
          3'b101:  dec.mem_read = 3'b101;
          default: dec_ill      = 1'b1;
        endcase
      end
      OP_STORE: begin
        dec.immi_sel   = 3'b010;
        dec.alu_source = 2'b01;
        case (fun3)
          3'b000:  dec.mem_write = 3'b001;
          3'b001:  dec.mem_write = 3'b010;
          3'b010:  dec.mem_write = 3'b011;
          default: dec_ill       = 1'b1;
        endcase
      end
      OP_BRANCH: begin
        dec.branch   = 1'b1;
        dec.immi_sel = 3'b100;
        dec.alu_op   = {2'b01, fun3};
        dec_ill      = (fun3 == 3'b010) || (fun3 == 3'b011);
      end
      OP_LUI: begin
        dec.reg_write  = 1'b1;
        dec.immi_sel   = 3'b011;
        dec.alu_source = 2'b01;
        dec.alu_op     = 5'b01010;
      end
      OP_AUIPC: begin
        dec.reg_write  = 1'b1;
        dec.immi_sel   = 3'b011;
        dec.alu_source = 2'b10;
      end
      OP_JAL: begin
        dec.reg_write  = 1'b1;
        dec.immi_sel   = 3'b101;
        dec.alu_source = 2'b10;
        dec.mem_to_reg = 2'b10;
        dec.pc_sel     = 1'b1;
      end
      OP_JALR: begin
        dec.reg_write  = 1'b1;
        dec.immi_sel   = 3'b001;
        dec.alu_source = 2'b01;
        dec.mem_to_reg = 2'b10;
        dec.pc_sel     = 1'b1;
        dec_ill        = (fun3 != 3'b000);
      end
      default: dec_ill = 1'b1;
    endcase
  end

  ctrl_t            bundle_d, bundle_q;
  logic             valid_d, valid_q;
  logic             illegal_d, illegal_q;
  state_t           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [CNT_W-1:0] md_ld;

  assign md_ld = fun3[2] ? DIV_LD : MUL_LD;

  always_comb begin
    bundle_d  = bundle_q;
    valid_d   = valid_q;
    illegal_d = illegal_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    if (FLUSH) begin
      bundle_d  = '0;
      valid_d   = 1'b0;
      illegal_d = 1'b0;
      state_d   = S_IDLE;
      cnt_d     = '0;
    end else if (state_q == S_MD_RUN) begin
      // Counts down regardless of STALL_IN; the bundle is held meanwhile.
      cnt_d = cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) begin
        state_d = S_IDLE;
      end
    end else if (!STALL_IN) begin
      bundle_d  = (IN_VALID && !dec_ill) ? dec : '0;
      valid_d   = IN_VALID && !dec_ill;
      illegal_d = IN_VALID && dec_ill;
      if (IN_VALID && !dec_ill && dec_mop && (md_ld != '0)) begin
        state_d = S_MD_RUN;
        cnt_d   = md_ld;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      bundle_q  <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
    end else begin
      bundle_q  <= bundle_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
    end
  end

  assign VALID_OUT  = valid_q;
  assign ILLEGAL    = illegal_q;
  assign STALL_OUT  = (state_q == S_MD_RUN);
  assign ALU_OP     = bundle_q.alu_op;
  assign MEM_READ   = bundle_q.mem_read;
  assign MEM_WRITE  = bundle_q.mem_write;
  assign IMMI_SEL   = bundle_q.immi_sel;
  assign MEM_TO_REG = bundle_q.mem_to_reg;
  assign ALU_SOURCE = bundle_q.alu_source;
  assign REG_WRITE  = bundle_q.reg_write;
  assign BRANCH     = bundle_q.branch;
  assign PC_SEL     = bundle_q.pc_sel;

endmodule
